// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared gradient constants and inverse-interpolator state type
package shader_pkg;

  localparam int          GRAD_FRAC_BITS = 14;
  localparam logic [15:0] GRAD_ONE       = 16'h4000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_FIN,
    ST_DONE
  } inv_state_t;

endpackage

// File: rtl/frac_div.sv
// rtl/frac_div.sv - restoring fractional divider, one quotient bit per step, MSB first
module frac_div #(
  parameter int NW        = 17,
  parameter int FRAC_BITS = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [NW-1:0]        num,
  input  logic [NW-1:0]        den,
  output logic [FRAC_BITS-1:0] q,
  output logic                 last
);
  localparam int CW = $clog2(FRAC_BITS);

  logic signed [NW:0] rem;
  logic signed [NW:0] shifted;
  logic signed [NW:0] den_ext;
  logic [NW-1:0]      den_q;
  logic [CW-1:0]      cnt;

  // den is already normalized non-negative, so zero-extension is exact
  assign shifted = {rem[NW-1:0], 1'b0};
  assign den_ext = {1'b0, den_q};
  assign last    = (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem   <= '0;
      den_q <= '0;
      q     <= '0;
      cnt   <= '0;
    end else if (load) begin
      rem   <= {num[NW-1], num};
      den_q <= den;
      q     <= '0;
      cnt   <= CW'(FRAC_BITS - 1);
    end else if (step) begin
      if (shifted >= den_ext) begin
        rem <= shifted - den_ext;
        q   <= {q[FRAC_BITS-2:0], 1'b1};
      end else begin
        rem <= shifted;
        q   <= {q[FRAC_BITS-2:0], 1'b0};
      end
      if (!last) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/inv_interpolate.sv
// rtl/inv_interpolate.sv - locate val between min_val and max_val as a clamped Q2.14 gradient
module inv_interpolate
  import shader_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = GRAD_FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] val,
  output logic             done,
  output logic [WIDTH-1:0] gradient
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

  inv_state_t state, next_state;

  logic [WIDTH-1:0]        min_q, max_q, val_q;
  logic                    zero_f, one_f;
  logic signed [WIDTH:0]   num_raw, den_raw, num_n, den_n;
  logic                    zero_c, one_c;
  logic                    load, step;
  logic [FRAC_BITS-1:0]    q;
  logic                    last;

  assign num_raw = $signed({1'b0, val_q}) - $signed({1'b0, min_q});
  assign den_raw = $signed({1'b0, max_q}) - $signed({1'b0, min_q});
  // a reversed span is handled by flipping both signs so den is always >= 0
  assign num_n   = den_raw[WIDTH] ? -num_raw : num_raw;
  assign den_n   = den_raw[WIDTH] ? -den_raw : den_raw;
  assign zero_c  = (den_n == '0) || num_n[WIDTH] || (num_n == '0);
  assign one_c   = !zero_c && (num_n >= den_n);

  frac_div #(
    .NW        (WIDTH + 1),
    .FRAC_BITS (FRAC_BITS)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .num     (num_n),
    .den     (den_n),
    .q       (q),
    .last    (last)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_PREP;
      ST_PREP: begin
        load       = 1'b1;
        next_state = ST_DIV;
      end
      ST_DIV: begin
        step = 1'b1;
        if (last) next_state = ST_FIN;
      end
      ST_FIN:  next_state = ST_DONE;
      ST_DONE: if (!start) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      min_q    <= '0;
      max_q    <= '0;
      val_q    <= '0;
      zero_f   <= 1'b0;
      one_f    <= 1'b0;
      done     <= 1'b0;
      gradient <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: if (start) begin
          min_q <= min_val;
          max_q <= max_val;
          val_q <= val;
        end
        ST_PREP: begin
          zero_f <= zero_c;
          one_f  <= one_c;
        end
        ST_FIN: begin
          done <= 1'b1;
          if (zero_f)     gradient <= '0;
          else if (one_f) gradient <= ONE;
          else            gradient <= {{(WIDTH-FRAC_BITS){1'b0}}, q};
        end
        ST_DONE: if (!start) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_interpolate.sv
// tb/tb_inv_interpolate.sv - directed and randomized checks of inv_interpolate against an arithmetic model
module tb_inv_interpolate;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] min_val = '0, max_val = '0, val = '0;
  logic        done;
  logic [15:0] gradient;
  int n_cmp = 0;
  int n_err = 0;

  inv_interpolate dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .min_val  (min_val),
    .max_val  (max_val),
    .val      (val),
    .done     (done),
    .gradient (gradient)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_grad(input int mn, input int mx, input int v);
    longint n, d;
    n = v - mn;
    d = mx - mn;
    if (d < 0) begin
      n = -n;
      d = -d;
    end
    if (d == 0 || n <= 0) return 16'h0000;
    if (n >= d) return 16'h4000;
    return 16'((n * 16384) / d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // raise start with operands, pass the sampling edge, then scramble inputs
  task automatic launch(input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] v);
    @(negedge clk);
    min_val = mn;
    max_val = mx;
    val     = v;
    start   = 1'b1;
    @(posedge clk);
    #1;
    min_val = 16'($urandom);
    max_val = 16'($urandom);
    val     = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drop_start(input string tag);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 32'(done), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] v);
    int lat;
    launch(mn, mx, v);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd16);
    check({tag, "_grad"}, 32'(gradient), 32'(ref_grad(int'(mn), int'(mx), int'(v))));
    drop_start(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] held, mn, mx, v;

    #12;
    check("rst_done", 32'(done), 32'd0);
    check("rst_grad", 32'(gradient), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("half", 16'd0, 16'd100, 16'd50);
    check("half_val", 32'(gradient), 32'h2000);
    run_op("third_a", 16'd10, 16'd40, 16'd20);
    check("third_a_val", 32'(gradient), 32'h1555);
    run_op("third_b", 16'd0, 16'd3, 16'd1);
    run_op("below", 16'd100, 16'd200, 16'd50);
    run_op("above", 16'd100, 16'd200, 16'd250);
    check("above_val", 32'(gradient), 32'h4000);
    run_op("at_max", 16'd100, 16'd200, 16'd200);
    run_op("at_min", 16'd100, 16'd200, 16'd100);
    run_op("rev_mid", 16'd200, 16'd100, 16'd150);
    check("rev_mid_val", 32'(gradient), 32'h2000);
    run_op("rev_hi", 16'd200, 16'd100, 16'd250);
    run_op("rev_lo", 16'd200, 16'd100, 16'd50);
    run_op("degen", 16'd77, 16'd77, 16'd77);
    run_op("full", 16'd0, 16'hFFFF, 16'hFFFE);
    run_op("rev_full", 16'hFFFF, 16'd0, 16'd1);

    // hold start for 30 cycles after done: single stable result
    launch(16'd0, 16'd8, 16'd3);
    wait_done(lat);
    check("hold_lat", 32'(lat), 32'd16);
    held = gradient;
    check("hold_grad", 32'(held), 32'h1800);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", 32'(done), 32'd1);
      check("hold_stable", 32'(gradient), 32'(held));
    end
    drop_start("hold");
    check("hold_keep", 32'(gradient), 32'h1800);
    run_op("rearm", 16'd50, 16'd60, 16'd55);

    // single-cycle start pulse gives a single-cycle done pulse
    launch(16'd0, 16'd5, 16'd4);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("pulse_lat", 32'(lat), 32'd16);
    check("pulse_grad", 32'(gradient), 32'h3333);
    @(posedge clk);
    #1;
    check("pulse_fall", 32'(done), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("pulse_idle", 32'(done), 32'd0);

    // asynchronous reset in the middle of the division
    launch(16'd0, 16'd100, 16'd50);
    repeat (7) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_done", 32'(done), 32'd0);
    check("arst_grad", 32'(gradient), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_quiet", 32'(done), 32'd0);
    run_op("post_rst", 16'd0, 16'd4, 16'd1);
    check("post_rst_val", 32'(gradient), 32'h1000);

    for (int i = 0; i < 40; i++) begin
      mn = 16'($urandom);
      if (i % 2 == 0) mx = mn + 16'($urandom_range(1, 300));
      else            mx = 16'($urandom);
      v = (i % 3 == 0) ? 16'($urandom) : mn + 16'($urandom_range(0, 300));
      run_op("rand", mn, mx, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
